// File: rtl/vend_pkg.sv
// Shared constants for the vending-machine input conditioner: channel count,
// channel bit positions and the released (idle) level of an active-low input.
package vend_pkg;

    localparam int NUM_CH = 8;

    localparam int IDX_L   = 0;
    localparam int IDX_R   = 1;
    localparam int IDX_U   = 2;
    localparam int IDX_D   = 3;
    localparam int IDX_SW0 = 4;
    localparam int IDX_SW1 = 5;
    localparam int IDX_SW2 = 6;
    localparam int IDX_SW3 = 7;

    localparam logic BTN_IDLE = 1'b1;

endpackage

// File: rtl/vend_debounce.sv
// One active-low input channel: 2-FF synchroniser, debounce counter, stable level
// and a one-cycle press strobe. Auto-repeat exists only when VEND_AUTOREPEAT_EN is defined.
module vend_debounce
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int CNT_W           = 8,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 5,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_n_o,
    output logic held_n_o
);

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    // Elaboration-time guard against parameter values the counters cannot honour.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
        (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_RATE < 1))) begin : g_bad_params
        $error("vend_debounce: illegal parameter combination");
    end

    logic             s1_q;
    logic             s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_n_q, press_n_d;
    logic             fall;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        cnt_inc  = cnt_q + CNT_W'(1);
        if (s2_q != stable_q) begin
            if (cnt_inc == DB_LIMIT) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        fall = stable_q & ~stable_d;
    end

`ifdef VEND_AUTOREPEAT_EN
    localparam int RPT_W = 16;

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] rpt_inc;
    logic             rpt_first_q, rpt_first_d;
    logic             rpt_fire;

    // The first repeat waits REPEAT_DELAY after the press strobe, later ones REPEAT_RATE.
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        rpt_fire    = 1'b0;
        rpt_inc     = rpt_cnt_q + RPT_W'(1);
        if (REPEAT_EN && !fall && !stable_q && !stable_d) begin
            rpt_first_d = rpt_first_q;
            if (rpt_inc == (rpt_first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE))) begin
                rpt_fire    = 1'b1;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_inc;
            end
        end
        press_n_d = ~(fall | rpt_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    always_comb begin
        press_n_d = ~fall;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= BTN_IDLE;
            s2_q      <= BTN_IDLE;
            stable_q  <= BTN_IDLE;
            cnt_q     <= '0;
            press_n_q <= 1'b1;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_n_q <= press_n_d;
        end
    end

    assign press_n_o = press_n_q;
    assign held_n_o  = stable_q;

endmodule

// File: rtl/vend_input_cond.sv
// Operator input conditioner: eight independent debounced active-low channels
// (L R U D SW0..SW3). Buttons auto-repeat only when VEND_AUTOREPEAT_EN is defined.
module vend_input_cond
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int CNT_W           = 8,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       L,
    input  logic       R,
    input  logic       U,
    input  logic       D,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    output logic [7:0] press_n,
    output logic [7:0] held_n
);

    logic [NUM_CH-1:0] raw;

    always_comb begin
        raw          = '1;
        raw[IDX_L]   = L;
        raw[IDX_R]   = R;
        raw[IDX_U]   = U;
        raw[IDX_D]   = D;
        raw[IDX_SW0] = SW0;
        raw[IDX_SW1] = SW1;
        raw[IDX_SW2] = SW2;
        raw[IDX_SW3] = SW3;
    end

    // Only the four push buttons are allowed to auto-repeat; switches never do.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        vend_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REPEAT_EN      (i <= IDX_D)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (raw[i]),
            .press_n_o(press_n[i]),
            .held_n_o (held_n[i])
        );
    end

endmodule

// File: doc/vend_input_cond.md
# vend_input_cond

Front-end conditioner for the vending machine's operator inputs. It accepts the raw active-low push buttons L, R, U, D and slide switches SW0–SW3, synchronises and debounces each one, and produces clean active-low press strobes, each one clock wide, plus debounced held levels. Its outputs drive the `vending` core's button/switch inputs, in the same active-low, one-cycle format that core consumes.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1 — consecutive synchronised samples that must differ from the stable level before it changes; legal 1..(2^CNT_W − 1).
- CNT_W, 8 — debounce counter width.
- REPEAT_DELAY, 20 — cycles from the first press strobe to the first auto-repeat strobe (VEND_AUTOREPEAT_EN only).
- REPEAT_RATE, 5 — cycles between subsequent auto-repeat strobes (VEND_AUTOREPEAT_EN only).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- L, R, U, D  in  1 each  raw buttons, active-low, asynchronous to clk.
- SW0, SW1, SW2, SW3  in  1 each  raw switches, active-low, asynchronous to clk.
- press_n  out  8  active-low one-cycle press strobes.
- held_n  out  8  debounced stable levels, active-low.

Bit mapping for both vectors: 0 L, 1 R, 2 U, 3 D, 4 SW0, 5 SW1, 6 SW2, 7 SW3.

## Operation
- Per-channel 2-FF synchroniser (s1 → s2). Both flops reset to 1 (released).
- Per-channel debounce:
  - Stable register reset to 1.
  - Counter reset to 0.
  - Each edge where s2 ≠ stable: counter increments.
  - Each edge where s2 = stable: counter clears.
  - When the increment would reach DEBOUNCE_CYCLES: stable ← s2, counter ← 0.
- held_n = stable register.
- press_n bit is registered. It is driven low for exactly one cycle on the edge where stable goes 1→0.
- A 0→1 (release) transition produces no strobe.
- Glitches shorter than DEBOUNCE_CYCLES synchronised samples are suppressed entirely.
- Channels are independent. Simultaneous presses on several channels produce strobes in the same cycle, with no prioritisation or serialisation.

## Timing
- Reset value of every output: press_n = 8'hFF, held_n = 8'hFF.
- Latency: let edge 0 be the first rising edge at which the raw input is low. Then stable and held_n fall at edge DEBOUNCE_CYCLES+1, and press_n is low from edge DEBOUNCE_CYCLES+1 to edge DEBOUNCE_CYCLES+2.
- Release latency is the same: held_n rises DEBOUNCE_CYCLES+1 edges after the raw input goes high.
- Reset mid-debounce: counters clear and synchronisers return to 1, with no strobe. An input held low through the release of rst is treated as a new press, with full latency measured from the first post-reset edge.
- rst has priority over all other updates in the same cycle.

## Configuration
- VEND_AUTOREPEAT_EN defined:
  - Applies to channels 0–3 (L, R, U, D) only.
  - While stable stays low, a repeat counter started at the initial strobe edge issues a further one-cycle strobe REPEAT_DELAY edges later, then every REPEAT_RATE edges.
  - Release (stable → 1) or rst clears the repeat counter immediately.
  - Switch channels 4–7 never repeat.
- VEND_AUTOREPEAT_EN undefined: no repeat logic is present, and every channel strobes exactly once per debounced press.

## Structure
- Shared package vend_pkg holds:
  - NUM_CH = 8.
  - Channel index constants IDX_L..IDX_SW3 (0..7).
  - Reset/idle level constant BTN_IDLE = 1'b1.
- Sub-module vend_debounce: one channel (synchroniser, counter, stable register, edge strobe, optional repeat counter). Instantiated NUM_CH times with a repeat-enable parameter set per channel.

## Test plan
Benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
1. rst high for 2 cycles, all inputs high, run 20 cycles → press_n = 8'hFF and held_n = 8'hFF throughout.
2. SW3 low for 3 cycles, then high → no strobe; held_n stays 8'hFF.
3. R low for 10 cycles → press_n = 8'hFD for exactly one cycle at edge 5; held_n[1] low from edge 5 to 5 edges after release; no strobe on release.
4. L and SW1 fall on the same edge, held for 10 cycles → press_n = 8'hDE for one cycle at edge 5.
5. U held low for 40 cycles:
   - VEND_AUTOREPEAT_EN defined → strobes at edges 5, 25, 30, 35, 40.
   - Undefined → a single strobe at edge 5.
   - SW0 held the same way → a single strobe in both builds.
6. D low; rst pulsed at edge 2 (mid-debounce); D kept low → outputs 8'hFF during reset, then a strobe on press_n[3] at edge 5 counted from the first post-reset edge.
